// File: rtl/bios_fetch_buffer_if.sv
// ---------------------------------------------------------------------------
// bios_fetch_buffer_if
// Bundles the fetch front-end's redirect input, its ROM port-A read bus and
// its decode-side valid/ready stream.
//   master : the fetch buffer (drives ROM request, instruction stream, fault)
//   slave  : the surrounding core/ROM/decode (drives redirect, ROM data, ready)
// Signals:
//   redirect, redirect_pc         new fetch target from the PC redirect logic
//   bios_ena, bios_addra          ROM port-A read request (word address)
//   bios_douta                    ROM data, valid the cycle after bios_ena
//   inst_valid, inst, inst_pc     FIFO head presented to decode
//   out_ready                     decode accepts the head this cycle
//   fetch_fault, fault_pc         fetch halted on an out-of-region PC
//   perf_fetched, perf_stall      present only with BIOS_FETCH_PERF_EN
// ---------------------------------------------------------------------------
interface bios_fetch_buffer_if #(
  parameter int ADDR_W = 12
);
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              bios_ena;
  logic [ADDR_W-1:0] bios_addra;
  logic [31:0]       bios_douta;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              out_ready;
  logic              fetch_fault;
  logic [31:0]       fault_pc;
`ifdef BIOS_FETCH_PERF_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_stall;

  modport master (
    input  redirect, redirect_pc, bios_douta, out_ready,
    output bios_ena, bios_addra, inst_valid, inst, inst_pc,
           fetch_fault, fault_pc, perf_fetched, perf_stall
  );
  modport slave (
    output redirect, redirect_pc, bios_douta, out_ready,
    input  bios_ena, bios_addra, inst_valid, inst, inst_pc,
           fetch_fault, fault_pc, perf_fetched, perf_stall
  );
`else
  modport master (
    input  redirect, redirect_pc, bios_douta, out_ready,
    output bios_ena, bios_addra, inst_valid, inst, inst_pc,
           fetch_fault, fault_pc
  );
  modport slave (
    output redirect, redirect_pc, bios_douta, out_ready,
    input  bios_ena, bios_addra, inst_valid, inst, inst_pc,
           fetch_fault, fault_pc
  );
`endif
endinterface

// File: rtl/bios_fetch_buffer.sv
// ---------------------------------------------------------------------------
// bios_fetch_buffer
// Instruction fetch front-end for the BIOS ROM. Issues PC-sequential reads to
// ROM port A (1-cycle synchronous read), captures the returned words into a
// small FIFO and presents them to decode with valid/ready. A redirect flushes
// the FIFO, kills the in-flight read and restarts fetch at the new PC; a PC
// outside the BIOS region halts fetch and raises fetch_fault.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bios_fetch_buffer_if.master (redirect, ROM port A, decode stream,
//          fault report)
// Optional feature: define BIOS_FETCH_PERF_EN to add perf_fetched/perf_stall
// counters on the interface.
// ---------------------------------------------------------------------------
module bios_fetch_buffer #(
  parameter logic [31:0] RESET_PC    = 32'h4000_0000,
  parameter logic [3:0]  BIOS_REGION = 4'h4,
  parameter int          ADDR_W      = 12,
  parameter int          DEPTH       = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  bios_fetch_buffer_if.master bus
);
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [0:0]        state;
  logic [31:0]       pc;
  logic              inflight;
  logic [31:0]       inflight_pc;
  logic [ADDR_W-1:0] addr_q;
  logic              fault_q;
  logic [31:0]       fault_pc_q;

  logic [31:0]       mem_inst [DEPTH];
  logic [31:0]       mem_pc   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  logic [31:0] issue_pc;
  logic        legal, active, issue, fault_now, pop, push, valid, has_room;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    issue_pc  = pc;
    has_room  = 1'b0;
    if (bus.redirect) issue_pc = bus.redirect_pc & ~32'h3;
    valid     = (count != '0);
    pop       = valid && bus.out_ready;
    legal     = (issue_pc[31:28] == BIOS_REGION);
    // Gating with rst_n keeps the ROM request quiet while reset is held.
    active    = rst_n && ((state == ST_RUN) || bus.redirect);
    // Occupancy after this edge must leave room for the read being issued;
    // a redirect flushes everything, so it always has room.
    if (int'(count) + int'(inflight) - int'(pop) < DEPTH) has_room = 1'b1;
    issue     = active && legal && (bus.redirect || has_room);
    fault_now = active && !legal;
    // A redirect kills the returning word on the same edge.
    push      = inflight && !bus.redirect;
  end

  assign bus.bios_ena    = issue;
  assign bus.bios_addra  = issue ? issue_pc[ADDR_W+1:2] : addr_q;
  assign bus.inst_valid  = valid;
  assign bus.inst        = valid ? mem_inst[rd_ptr] : '0;
  assign bus.inst_pc     = valid ? mem_pc[rd_ptr]   : '0;
  assign bus.fetch_fault = fault_q;
  assign bus.fault_pc    = fault_pc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      addr_q      <= '0;
      fault_q     <= 1'b0;
      fault_pc_q  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= issue_pc + 32'd4;
        inflight_pc <= issue_pc;
        addr_q      <= issue_pc[ADDR_W+1:2];
      end else begin
        pc <= issue_pc;
      end

      if (fault_now) begin
        state      <= ST_HALT;
        fault_q    <= 1'b1;
        fault_pc_q <= issue_pc;
      end else if (bus.redirect) begin
        state   <= ST_RUN;
        fault_q <= 1'b0;
      end

      // The head transfer (if any) completes before the flush; pointers are
      // realigned so the FIFO is empty afterwards.
      if (bus.redirect) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // NOTE: the FIFO storage has no reset; outputs are masked by inst_valid and
  // an entry is always written before it can be read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= bus.bios_douta;
      mem_pc[wr_ptr]   <= inflight_pc;
    end
  end

  // The issue rule reserves a slot for every in-flight read.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CNT_W'(DEPTH))));

`ifdef BIOS_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  // Counters survive redirects; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop)                       perf_fetched_q <= perf_fetched_q + 32'd1;
      if (valid && !bus.out_ready)   perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_stall   = perf_stall_q;
`else
`endif
endmodule

// File: tb/tb_bios_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_bios_fetch_buffer
// Self-checking bench for bios_fetch_buffer: directed scenarios followed by
// randomized redirect/backpressure traffic, compared every cycle against a
// queue-based reference model of the fetch front-end. A behavioural ROM
// returns word n = 32'h1000_0000 + n one cycle after each read.
// ---------------------------------------------------------------------------
module tb_bios_fetch_buffer;
  localparam int          ADDR_W   = 12;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bios_fetch_buffer_if #(.ADDR_W(ADDR_W)) bus ();

  bios_fetch_buffer #(
    .RESET_PC(RESET_PC), .BIOS_REGION(4'h4), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Behavioural ROM port A.
  always @(posedge clk)
    if (bus.bios_ena) bus.bios_douta <= 32'h1000_0000 + 32'(bus.bios_addra);

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] data; logic [31:0] pc; } entry_t;
  entry_t            q[$];
  logic [31:0]       m_pc, m_infl_pc, m_infl_data, m_fault_pc;
  bit                m_halt, m_infl, m_fault;
  logic [ADDR_W-1:0] m_addr;
  int                m_fetched, m_stall;

  function automatic logic [31:0] rom_word(input logic [31:0] p);
    return 32'h1000_0000 + 32'(p[ADDR_W+1:2]);
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc = RESET_PC; m_halt = 0; m_infl = 0; m_fault = 0;
    m_fault_pc = '0; m_addr = '0; m_infl_pc = '0; m_infl_data = '0;
    m_fetched = 0; m_stall = 0;
  endtask

  // One clock cycle: drive inputs (called at a falling edge), check the
  // DUT's outputs against the model, then advance the model across the edge.
  task automatic step(input bit rd, input logic [31:0] rpc, input bit rdy);
    logic [31:0] ipc;
    bit legal, vld, pop, ena, fault_now;
    int occ;
    bus.redirect = rd; bus.redirect_pc = rpc; bus.out_ready = rdy;
    #1;
    ipc       = rd ? {rpc[31:2], 2'b00} : m_pc;
    legal     = (ipc[31:28] == 4'h4);
    vld       = (q.size() > 0);
    pop       = vld && rdy;
    occ       = q.size() + int'(m_infl) - int'(pop);
    ena       = (!m_halt || rd) && legal && (rd || occ < DEPTH);
    fault_now = (!m_halt || rd) && !legal;

    check("bios_ena",   32'(bus.bios_ena), 32'(ena));
    check("bios_addra", 32'(bus.bios_addra), ena ? 32'(ipc[ADDR_W+1:2]) : 32'(m_addr));
    check("inst_valid", 32'(bus.inst_valid), 32'(vld));
    if (vld) begin
      check("inst",    bus.inst,    q[0].data);
      check("inst_pc", bus.inst_pc, q[0].pc);
    end
    check("fetch_fault", 32'(bus.fetch_fault), 32'(m_fault));
    check("fault_pc",    bus.fault_pc, m_fault_pc);
`ifdef BIOS_FETCH_PERF_EN
    check("perf_fetched", bus.perf_fetched, 32'(m_fetched));
    check("perf_stall",   bus.perf_stall,   32'(m_stall));
`endif

    @(posedge clk);
    if (pop) m_fetched++;
    if (vld && !rdy) m_stall++;
    if (rd) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (m_infl) q.push_back('{data: m_infl_data, pc: m_infl_pc});
    end
    if (fault_now) begin
      m_fault = 1; m_fault_pc = ipc; m_halt = 1;
    end else if (rd) begin
      m_fault = 0; m_halt = 0;
    end
    m_infl = ena;
    if (ena) begin
      m_infl_pc = ipc; m_infl_data = rom_word(ipc); m_addr = ipc[ADDR_W+1:2];
    end
    m_pc = ena ? ipc + 32'd4 : ipc;
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, rdy);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inst_valid"},  32'(bus.inst_valid), 32'h0);
    check({tag, "_bios_ena"},    32'(bus.bios_ena), 32'h0);
    check({tag, "_bios_addra"},  32'(bus.bios_addra), 32'h0);
    check({tag, "_fetch_fault"}, 32'(bus.fetch_fault), 32'h0);
    check({tag, "_fault_pc"},    bus.fault_pc, 32'h0);
    check({tag, "_inst"},        bus.inst, 32'h0);
    check({tag, "_inst_pc"},     bus.inst_pc, 32'h0);
  endtask

  initial begin
    bus.redirect = 0; bus.redirect_pc = '0; bus.out_ready = 0;
    model_reset();
    #1;
    check_reset_outputs("rst0");

    // Release reset at a falling edge; the next rising edge issues RESET_PC.
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Sequential streaming.
    run(10, 1'b1);
    // Backpressure: FIFO fills to DEPTH, issue stops, head holds.
    run(5, 1'b0);
    run(8, 1'b1);

    // Redirect with buffered and in-flight words outstanding.
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h4000_0100, 1'b0);
    run(6, 1'b1);

    // Illegal redirect halts fetch; legal redirect resumes.
    step(1'b1, 32'h1000_0000, 1'b1);
    run(4, 1'b1);
    step(1'b1, 32'h4000_0000, 1'b0);
    run(6, 1'b1);

    // Word address wraps within the region.
    step(1'b1, 32'h4000_3FF8, 1'b1);
    run(6, 1'b1);

    // Redirect and pop in the same cycle.
    step(1'b1, 32'h4000_0200, 1'b1);
    run(3, 1'b1);
    step(1'b1, 32'h4000_0300, 1'b1);
    run(4, 1'b1);

    // Sequential crossing out of the region under backpressure: fault with
    // words still buffered, then asynchronous reset between clock edges.
    step(1'b1, 32'h4FFF_FFF8, 1'b0);
    run(4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk); @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    run(6, 1'b1);

    // Randomized redirects, illegal targets and backpressure.
    for (int i = 0; i < 600; i++) begin
      bit rd, rdy;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 3) != 0);
      rd  = m_halt ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 15) == 0);
      rpc = {4'h4, 28'($urandom)};
      if ($urandom_range(0, 7) == 0) rpc[31:28] = 4'($urandom);
      if ($urandom_range(0, 5) == 0) rpc = 32'h4FFF_FFF0 | 32'($urandom_range(0, 15));
      step(rd, rpc, rdy);
    end
    run(6, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
